// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared CPU definitions for the memory arbiter (states, access sizes, IO region).
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} arb_state_e;
  typedef enum logic [1:0] {LEN_BYTE = 2'b00, LEN_HALF = 2'b01, LEN_WORD = 2'b10, LEN_WORD_ALT = 2'b11} lsb_len_e;
  localparam logic [1:0] IO_REGION = 2'b11;
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    return len == LEN_BYTE ? 3'd1 : len == LEN_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetch and load/store traffic onto a byte-wide RAM port.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_ready,
  input  logic [31:0] if_addr,
  output logic        if_ok,
  output logic [31:0] if_data,
  input  logic        lsb_ready,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_ok,
  output logic [31:0] lsb_rdata,
  input  logic        rob_clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);
  arb_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, nb_q, nb_d;
  logic        last_lsb_q, last_lsb_d;
  logic [31:0] base_q, base_d, wdata_q, wdata_d;
  logic [31:0] if_data_q, if_data_d, lsb_rdata_q, lsb_rdata_d, mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        if_ok_q, if_ok_d, lsb_ok_q, lsb_ok_d, mem_wr_q, mem_wr_d;
  logic        pick_lsb, stall;
  logic [1:0]  lane;
  assign pick_lsb = lsb_ready && (!if_ready || !last_lsb_q);
  // The grant cycle checks the incoming address; later bytes use the latched base.
  assign stall = io_buffer_full && (state_q == IDLE ? lsb_addr[17:16] : base_q[17:16]) == IO_REGION;
  assign lane = cnt_q[1:0] - 2'd1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_lsb_d = last_lsb_q;
    base_d = base_q;
    nb_d = nb_q;
    wdata_d = wdata_q;
    if_data_d = if_data_q;
    lsb_rdata_d = lsb_rdata_q;
    mem_dout_d = mem_dout_q;
    if_ok_d = 1'b0;
    lsb_ok_d = 1'b0;
    mem_wr_d = 1'b0;
    mem_a_d = '0;
    case (state_q)
      IDLE: if (!rob_clear && (if_ready || lsb_ready)) begin
        last_lsb_d = pick_lsb;
        base_d = pick_lsb ? lsb_addr : if_addr;
        nb_d = pick_lsb ? len_bytes(lsb_len) : 3'd4;
        wdata_d = lsb_wdata;
        cnt_d = '0;
        if (pick_lsb && lsb_wr) begin
          state_d = LS_WR;
          if (!stall) begin
            mem_wr_d = 1'b1;
            mem_a_d = lsb_addr;
            mem_dout_d = lsb_wdata[7:0];
            cnt_d = 3'd1;
          end
        end else begin
          state_d = pick_lsb ? LS_RD : IF_RD;
          mem_a_d = base_d;
          if (pick_lsb) lsb_rdata_d = '0;
          else if_data_d = '0;
        end
      end
      IF_RD, LS_RD: if (if_ok_q || lsb_ok_q || rob_clear) begin
        state_d = IDLE;
        cnt_d = '0;
      end else begin
        // Counter runs one ahead of the returning byte because of RAM read latency.
        cnt_d = cnt_q + 3'd1;
        if (cnt_q != '0 && state_q == IF_RD) if_data_d[{lane, 3'b000} +: 8] = mem_din;
        if (cnt_q != '0 && state_q == LS_RD) lsb_rdata_d[{lane, 3'b000} +: 8] = mem_din;
        if (cnt_d < nb_q) mem_a_d = base_q + 32'(cnt_d);
        if_ok_d = state_q == IF_RD && cnt_q == nb_q;
        lsb_ok_d = state_q == LS_RD && cnt_q == nb_q;
      end
      LS_WR: if (lsb_ok_q) begin
        state_d = IDLE;
        cnt_d = '0;
      end else if (cnt_q == nb_q) lsb_ok_d = 1'b1;
      else if (!stall) begin
        mem_wr_d = 1'b1;
        mem_a_d = base_q + 32'(cnt_q);
        mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d = cnt_q + 3'd1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      nb_q <= '0;
      last_lsb_q <= 1'b0;
      base_q <= '0;
      wdata_q <= '0;
      if_data_q <= '0;
      lsb_rdata_q <= '0;
      mem_a_q <= '0;
      mem_dout_q <= '0;
      if_ok_q <= 1'b0;
      lsb_ok_q <= 1'b0;
      mem_wr_q <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      nb_q <= nb_d;
      last_lsb_q <= last_lsb_d;
      base_q <= base_d;
      wdata_q <= wdata_d;
      if_data_q <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
      mem_a_q <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      if_ok_q <= if_ok_d;
      lsb_ok_q <= lsb_ok_d;
      mem_wr_q <= mem_wr_d;
    end
  end
  assign if_ok = if_ok_q;
  assign if_data = if_data_q;
  assign lsb_ok = lsb_ok_q;
  assign lsb_rdata = lsb_rdata_q;
  assign mem_a = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr = mem_wr_q & rdy;
endmodule
